fp32_product_accumulator: RTL
=============================

// Module: fp32_product_accumulator
// PURPOSE
//  Downstream consumer of the FP32 multiplier: accepts {result, Exception, Overflow, Underflow} per product
//  and sums a stream of products into one FP32 accumulator using a multi-cycle align/add/normalise FSM.
//  Emits the dot-product sum with sticky flags when the input tagged last has been absorbed. Forms the MAC back end.
// PARAMETERS
//  ACC_INIT  32'h0000_0000  accumulator value after reset and after each output handshake
//  CNT_W     16             width of term counter (used only with FP_ACC_COUNT_EN)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   synchronous active-high reset
//  in_valid      in   1   product present
//  in_ready      out  1   block can accept product (high only in IDLE)
//  in_result     in   32  FP32 product from the multiplier
//  in_exception  in   1   multiplier Exception flag
//  in_overflow   in   1   multiplier Overflow flag
//  in_underflow  in   1   multiplier Underflow flag
//  in_last       in   1   final term of the current sum
//  out_valid     out  1   acc_result valid; held until out_ready
//  out_ready     in   1   downstream accepts result
//  acc_result    out  32  FP32 sum
//  acc_exception out  1   sticky: any term had in_exception
//  acc_overflow  out  1   sticky: any term or internal add overflowed
//  acc_underflow out  1   sticky: any term or internal add underflowed/flushed
//  acc_count     out  CNT_W  terms absorbed (FP_ACC_COUNT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, acc=ACC_INIT, in_ready=1, out_valid=0, acc_result=ACC_INIT, all sticky flags 0, acc_count=0.
//  States: IDLE -> ALIGN -> ADD -> NORM -> (IDLE | DONE) ; DONE -> IDLE on out_valid&out_ready.
//  IDLE: on in_valid&in_ready latch term + flags + last; OR term flags into sticky flags; go to ALIGN.
//   Term with in_exception=1 is treated as +0 (value discarded), flag still recorded.
//  Unpack: exponent 0 => value zero (denormals flushed); else mantissa = {1,frac} 24 bits.
//  ALIGN (1 cycle): larger-exponent operand = A; B mantissa >> (eA-eB); shift >= 25 => B = 0. Zero operand passes other.
//  ADD (1 cycle): equal signs => 25-bit sum, sign of A; else larger magnitude minus smaller, sign of larger;
//   exact cancellation => +0 (sign 0), skip to NORM-complete.
//  NORM: carry bit set => >>1, exp+1 (1 cycle). Else shift left 1 bit/cycle, exp-1, until mantissa[23]=1 (<=23 cycles).
//   Rounding = truncation (matches multiplier). Exponent >= 255 => {sign,8'hFF,23'd0}, acc_overflow=1.
//   Exponent reaches 0 before normalised => {sign,31'd0}, acc_underflow=1.
//  NORM done: write acc; last=0 => IDLE; last=1 => DONE with acc_result=acc, out_valid=1.
//  Latency per term: 1 accept + ALIGN + ADD + 1..24 NORM cycles; in_ready=0 from accept until return to IDLE.
//  DONE: outputs stable while out_valid&!out_ready. On handshake: acc=ACC_INIT, sticky flags and acc_count clear,
//   out_valid=0, IDLE; in_ready rises the following cycle (no same-cycle accept).
//  acc_result updates only on entry to DONE; holds last sum otherwise.
//  Infinity term (exp 255, Exception=0 cannot occur from multiplier) handled as overflow: result inf, acc_overflow=1.
//  rst mid-operation: immediate return to reset state; in-flight term lost.
// CONFIGURATION
//  FP_ACC_COUNT_EN defined: acc_count port present; +1 per accepted term (incl. exception terms), saturates at
//   2^CNT_W-1, cleared on output handshake/reset. Undefined: port and counter absent; all else identical.
// TESTING
//  3F800000 then 40000000(last) -> acc_result=40400000, flags 0, out_valid until out_ready.
//  3F800000 then BF800000(last) -> acc_result=00000000 (+0), flags 0.
//  3F800000 then 33800000(last) -> acc_result=3F800000 (B shifted out, truncated).
//  7F7FFFFF then 7F7FFFFF(last) -> acc_result=7F800000, acc_overflow=1; next sum after handshake starts clean.
//  40400000, then in_exception=1 term, then 3F800000(last) -> 40800000, acc_exception=1, acc_count=3 (COUNT_EN).
//  rst asserted in NORM of 2nd term -> next cycle in_ready=1, out_valid=0, acc=ACC_INIT, flags 0.

Source files
------------

// File: rtl/fp32_product_accumulator.sv
// fp32_product_accumulator
//   MAC back end: sums a stream of FP32 products (with their multiplier
//   flags) into one FP32 accumulator. Each term takes one multi-cycle trip
//   through an align / add / normalise FSM. Rounding is truncation.
//   The sum and sticky flags are presented when the term tagged last has
//   been absorbed.
//   Optional feature macro: FP_ACC_COUNT_EN adds the acc_count port and a
//   saturating term counter.
module fp32_product_accumulator #(
  parameter logic [31:0] ACC_INIT = 32'h0000_0000
`ifdef FP_ACC_COUNT_EN
  ,
  parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_exception,
  input  logic             in_overflow,
  input  logic             in_underflow,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      acc_result,
  output logic             acc_exception,
  output logic             acc_overflow,
  output logic             acc_underflow
`ifdef FP_ACC_COUNT_EN
  ,
  output logic [CNT_W-1:0] acc_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;         // running sum
  logic [31:0] term_q, term_d;       // latched term (+0 if exception)
  logic        last_q, last_d;
  logic        exc_q, exc_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [31:0] res_q, res_d;         // presented sum
  logic        sign_a_q, sign_a_d;   // sign of A, later sign of the sum
  logic        sign_b_q, sign_b_d;
  logic [8:0]  exp_q, exp_d;         // working exponent, one spare bit for carry
  logic [23:0] man_a_q, man_a_d;
  logic [23:0] man_b_q, man_b_d;     // B mantissa already aligned to A
  logic [24:0] sum_q, sum_d;         // 25-bit sum with carry bit
`ifdef FP_ACC_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Unpack both operands; exponent 0 means zero (denormals flushed).
  logic [7:0]  exp_acc, exp_trm, exp_diff;
  logic [23:0] man_acc, man_trm, man_small, man_aligned;
  logic        acc_inf, trm_inf, acc_big;

  assign exp_acc     = acc_q[30:23];
  assign exp_trm     = term_q[30:23];
  assign man_acc     = (exp_acc == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
  assign man_trm     = (exp_trm == 8'd0) ? 24'd0 : {1'b1, term_q[22:0]};
  assign acc_inf     = (exp_acc == 8'hFF);
  assign trm_inf     = (exp_trm == 8'hFF);
  assign acc_big     = (exp_acc >= exp_trm);
  assign exp_diff    = acc_big ? (exp_acc - exp_trm) : (exp_trm - exp_acc);
  assign man_small   = acc_big ? man_trm : man_acc;
  assign man_aligned = (exp_diff >= 8'd25) ? 24'd0 : (man_small >> exp_diff);

  // Normalisation scratch values, produced by the next-state logic.
  logic [8:0]  norm_exp;
  logic [23:0] norm_man;
  logic        norm_fin;
  logic [31:0] norm_word;

  // Next-state and datapath logic for the align/add/normalise FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    term_d    = term_q;
    last_d    = last_q;
    exc_d     = exc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    res_d     = res_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    exp_d     = exp_q;
    man_a_d   = man_a_q;
    man_b_d   = man_b_q;
    sum_d     = sum_q;
    norm_exp  = exp_q;
    norm_man  = sum_q[23:0];
    norm_fin  = 1'b0;
    norm_word = 32'd0;
`ifdef FP_ACC_COUNT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          term_d  = in_exception ? 32'd0 : in_result;
          last_d  = in_last;
          exc_d   = exc_q | in_exception;
          ovf_d   = ovf_q | in_overflow;
          unf_d   = unf_q | in_underflow;
`ifdef FP_ACC_COUNT_EN
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
`endif
          state_d = S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (acc_inf || trm_inf) begin
          // An infinite operand forces the result to overflow to infinity.
          sign_a_d = acc_inf ? acc_q[31] : term_q[31];
          sign_b_d = acc_inf ? acc_q[31] : term_q[31];
          exp_d    = 9'd255;
          man_a_d  = 24'h80_0000;
          man_b_d  = 24'd0;
        end else begin
          sign_a_d = acc_big ? acc_q[31] : term_q[31];
          sign_b_d = acc_big ? term_q[31] : acc_q[31];
          exp_d    = {1'b0, (acc_big ? exp_acc : exp_trm)};
          man_a_d  = acc_big ? man_acc : man_trm;
          man_b_d  = man_aligned;
        end
        state_d = S_ADD;
      end

      S_ADD: begin
        if (sign_a_q == sign_b_q) begin
          sum_d = {1'b0, man_a_q} + {1'b0, man_b_q};
        end else if (man_a_q >= man_b_q) begin
          sum_d = {1'b0, man_a_q} - {1'b0, man_b_q};
        end else begin
          sum_d    = {1'b0, man_b_q} - {1'b0, man_a_q};
          sign_a_d = sign_b_q;
        end
        state_d = S_NORM;
      end

      S_NORM: begin
        if (sum_q == 25'd0) begin
          // Exact cancellation (or zero plus zero) yields +0.
          norm_fin  = 1'b1;
          norm_word = 32'd0;
        end else begin
          if (sum_q[24]) begin
            norm_exp = exp_q + 9'd1;
            norm_man = sum_q[24:1];
            norm_fin = 1'b1;
          end else if (sum_q[23]) begin
            norm_exp = exp_q;
            norm_man = sum_q[23:0];
            norm_fin = 1'b1;
          end else begin
            // One left shift per cycle until the hidden bit reaches bit 23.
            norm_exp = exp_q - 9'd1;
            norm_man = {sum_q[22:0], 1'b0};
            norm_fin = norm_man[23] || (norm_exp == 9'd0);
            sum_d    = {1'b0, norm_man};
            exp_d    = norm_exp;
          end
          if (norm_exp >= 9'd255) begin
            norm_word = {sign_a_q, 8'hFF, 23'd0};
            if (norm_fin) ovf_d = 1'b1;
          end else if (norm_exp == 9'd0) begin
            norm_word = {sign_a_q, 31'd0};
            if (norm_fin) unf_d = 1'b1;
          end else begin
            norm_word = {sign_a_q, norm_exp[7:0], norm_man[22:0]};
          end
        end
        if (norm_fin) begin
          acc_d = norm_word;
          if (last_q) begin
            res_d   = norm_word;
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          acc_d   = ACC_INIT;
          exc_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
`ifdef FP_ACC_COUNT_EN
          cnt_d   = '0;
`endif
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= ACC_INIT;
      term_q   <= 32'd0;
      last_q   <= 1'b0;
      exc_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      res_q    <= ACC_INIT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exp_q    <= 9'd0;
      man_a_q  <= 24'd0;
      man_b_q  <= 24'd0;
      sum_q    <= 25'd0;
`ifdef FP_ACC_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      term_q   <= term_d;
      last_q   <= last_d;
      exc_q    <= exc_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      res_q    <= res_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      exp_q    <= exp_d;
      man_a_q  <= man_a_d;
      man_b_q  <= man_b_d;
      sum_q    <= sum_d;
`ifdef FP_ACC_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign acc_result    = res_q;
  assign acc_exception = exc_q;
  assign acc_overflow  = ovf_q;
  assign acc_underflow = unf_q;
`ifdef FP_ACC_COUNT_EN
  assign acc_count     = cnt_q;
`endif

endmodule
